alarm_seq: RTL

- Alarm sequencer for the digital clock.
- Stores an alarm time and compares it against the running h/m/s from the time core on every tick.
- Sequences the ring / snooze / dismiss cycle and drives the alarm_on and alarming flags for the HEX status displays and the LED pattern.
- Sits beside ctrl and is clocked by the tik output.

---
 rtl/alarm_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alarm_seq.sv
// rtl/alarm_seq.sv - alarm time store and ring/snooze/dismiss sequencer
// Outputs are registered from next-state values so each reflects its cause one clk later.
module alarm_seq #(
  parameter int MAX_H      = 23,
  parameter int MAX_M      = 59,
  parameter int RING_S     = 30,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [5:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  input  logic [5:0] set_h,
  input  logic [5:0] set_m,
  input  logic       set_load,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] alm_h,
  output logic [5:0] alm_m,
  output logic       alarm_on,
  output logic       alarming,
  output logic [3:0] led,
  output logic [1:0] snz_used
);

  localparam int RW = (RING_S > 1) ? $clog2(RING_S) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_S - 1);
  localparam logic [8:0]    SNZ_INIT  = 9'(SNOOZE_S - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);
  localparam logic [5:0]    H_LIM     = 6'(MAX_H);
  localparam logic [5:0]    M_LIM     = 6'(MAX_M);

  typedef enum logic [1:0] {IDLE, ARMED, RING, SNOOZE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] ring_cnt, ring_nxt;
  logic [8:0]    snz_cnt, snz_cnt_nxt;
  logic [1:0]    used_nxt;
  logic [5:0]    alm_h_nxt, alm_m_nxt;
  logic [3:0]    led_nxt;
  logic          load_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_used <= '0;
      alm_h    <= '0;
      alm_m    <= '0;
      alarm_on <= 1'b0;
      alarming <= 1'b0;
      led      <= '0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_nxt;
      snz_cnt  <= snz_cnt_nxt;
      snz_used <= used_nxt;
      alm_h    <= alm_h_nxt;
      alm_m    <= alm_m_nxt;
      alarm_on <= (state_nxt != IDLE);
      alarming <= (state_nxt == RING);
      led      <= led_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ring_nxt    = ring_cnt;
    snz_cnt_nxt = snz_cnt;
    used_nxt    = snz_used;
    alm_h_nxt   = alm_h;
    alm_m_nxt   = alm_m;
    led_nxt     = led;
    load_ok     = set_load && (set_h <= H_LIM) && (set_m <= M_LIM);

    if (load_ok) begin
      alm_h_nxt = set_h;
      alm_m_nxt = set_m;
    end

    if (!arm) begin
      state_nxt = IDLE;
      ring_nxt  = '0;
      used_nxt  = '0;
    end else if (set_load && (state == RING || state == SNOOZE)) begin
      // any load attempt while sounding swallows this cycle's stop/snooze/tick
      if (load_ok) begin
        state_nxt = ARMED;
        used_nxt  = '0;
      end
    end else begin
      case (state)
        IDLE: state_nxt = ARMED;
        ARMED: begin
          if (tick && cur_h == alm_h && cur_m == alm_m && cur_s == 6'd0) begin
            state_nxt = RING;
            ring_nxt  = '0;
            used_nxt  = '0;
          end
        end
        RING: begin
          if (stop) begin
            state_nxt = ARMED;
            used_nxt  = '0;
          end else if (snooze && snz_used < SNZ_MAX) begin
            state_nxt   = SNOOZE;
            snz_cnt_nxt = SNZ_INIT;
            used_nxt    = snz_used + 2'd1;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state_nxt = ARMED;
              used_nxt  = '0;
            end else begin
              ring_nxt = ring_cnt + 1'b1;
              led_nxt  = ~led;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_nxt = ARMED;
            used_nxt  = '0;
          end else if (tick) begin
            if (snz_cnt == 9'd0) begin
              state_nxt = RING;
              ring_nxt  = '0;
            end else begin
              snz_cnt_nxt = snz_cnt - 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt == RING && state != RING) led_nxt = 4'b1010;
    else if (state_nxt == SNOOZE)           led_nxt = 4'b0001;
    else if (state_nxt != RING)             led_nxt = 4'b0000;
  end

endmodule
